// File: rtl/constants_pkg.sv
// Shared constants and types for the register file and its neighbours.
package constants_pkg;

  localparam int REGISTER_DATA_BITS = 8;
  localparam int REGFILE_NUM_REGS   = 16;

  typedef logic [REGFILE_NUM_REGS-1:0] regfile_busy_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: address mux, write-first bypass, data/ready flops.
// Latency 1; rd_data holds when not enabled, rd_ready drops to 0.
module regfile_read_port #(
  parameter int DATA_BITS = 8,
  parameter int NUM_REGS  = 16,
  parameter int ADDR_BITS = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REGS-1:0][DATA_BITS-1:0] regs_i,
  input  logic [NUM_REGS-1:0]                busy_i,
  input  logic                               wr_enable_i,
  input  logic [ADDR_BITS-1:0]               wr_addr_i,
  input  logic [DATA_BITS-1:0]               wr_data_i,
  input  logic                               rd_enable_i,
  input  logic [ADDR_BITS-1:0]               rd_addr_i,
  output logic [DATA_BITS-1:0]               rd_data_o,
  output logic                               rd_ready_o
);

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 in_range;

  assign in_range = int'(rd_addr_i) < NUM_REGS;

  always_comb begin
    data_d  = data_q;
    ready_d = 1'b0;
    if (rd_enable_i) begin
      if (!in_range) begin
        data_d  = '0;
        ready_d = 1'b1;
      end else if (wr_enable_i && (wr_addr_i == rd_addr_i)) begin
        // wr_enable_i is already qualified by the top (range, hardwired zero).
        data_d  = wr_data_i;
        ready_d = 1'b1;
      end else begin
        data_d  = regs_i[rd_addr_i];
        ready_d = !busy_i[rd_addr_i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_ready_o = ready_q;

endmodule

// File: rtl/register_file_sb.sv
// NUM_REGS x DATA_BITS register file, 2 registered read ports, 1 write, busy scoreboard.
// REGFILE_ZERO_REG_EN hardwires register 0 to zero (writes dropped, never busy).
module register_file_sb
  import constants_pkg::*;
#(
  parameter int DATA_BITS = REGISTER_DATA_BITS,
  parameter int NUM_REGS  = REGFILE_NUM_REGS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(NUM_REGS)-1:0]  rd0_addr,
  input  logic                         rd0_enable,
  output logic [DATA_BITS-1:0]         rd0_data,
  output logic                         rd0_ready,
  input  logic [$clog2(NUM_REGS)-1:0]  rd1_addr,
  input  logic                         rd1_enable,
  output logic [DATA_BITS-1:0]         rd1_data,
  output logic                         rd1_ready,
  input  logic [$clog2(NUM_REGS)-1:0]  wr_addr,
  input  logic                         wr_enable,
  input  logic [DATA_BITS-1:0]         wr_data,
  input  logic [$clog2(NUM_REGS)-1:0]  rsv_addr,
  input  logic                         rsv_enable,
  output logic                         rsv_ok,
  output logic [NUM_REGS-1:0]          busy_mask,
  output logic                         err_double_rsv
);

  localparam int ADDR_BITS = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0][DATA_BITS-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                busy_q, busy_d;
  logic                               err_q, err_d;
  logic                               wr_in_range, rsv_in_range, wr_store;

  assign wr_in_range  = int'(wr_addr) < NUM_REGS;
  assign rsv_in_range = int'(rsv_addr) < NUM_REGS;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_store = wr_enable && wr_in_range && (wr_addr != '0);
`else
  assign wr_store = wr_enable && wr_in_range;
`endif

  // A same-cycle writeback frees the slot, so a new producer may claim it.
  assign rsv_ok = rsv_in_range &&
                  (!busy_q[rsv_addr] || (wr_enable && (wr_addr == rsv_addr)));

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_store) begin
      regs_d[wr_addr] = wr_data;
    end
    if (wr_enable && wr_in_range) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (rsv_enable) begin
      if (rsv_ok) begin
        busy_d[rsv_addr] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
`ifdef REGFILE_ZERO_REG_EN
    busy_d[0] = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_mask      = busy_q;
  assign err_double_rsv = err_q;

  regfile_read_port #(
    .DATA_BITS (DATA_BITS),
    .NUM_REGS  (NUM_REGS),
    .ADDR_BITS (ADDR_BITS)
  ) u_rd0 (
    .clk         (clk),
    .reset       (reset),
    .regs_i      (regs_q),
    .busy_i      (busy_q),
    .wr_enable_i (wr_store),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_enable_i (rd0_enable),
    .rd_addr_i   (rd0_addr),
    .rd_data_o   (rd0_data),
    .rd_ready_o  (rd0_ready)
  );

  regfile_read_port #(
    .DATA_BITS (DATA_BITS),
    .NUM_REGS  (NUM_REGS),
    .ADDR_BITS (ADDR_BITS)
  ) u_rd1 (
    .clk         (clk),
    .reset       (reset),
    .regs_i      (regs_q),
    .busy_i      (busy_q),
    .wr_enable_i (wr_store),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_enable_i (rd1_enable),
    .rd_addr_i   (rd1_addr),
    .rd_data_o   (rd1_data),
    .rd_ready_o  (rd1_ready)
  );

endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the 16x2R1W register file. Depth and width are configurable.
- Read ports are registered, with write-to-read bypass.
- A per-register busy scoreboard lets the pipelined control unit reserve a destination at issue and clear it at writeback.
- Sits between decode/issue (reservations, operand reads) and the ALU/memory writeback path.

Parameters:
- DATA_BITS, REGISTER_DATA_BITS, width of each register.
- NUM_REGS, REGFILE_NUM_REGS (16), number of registers; legal range 2..256.
- ADDR_BITS, $clog2(NUM_REGS), address width; derived, must not be overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- rd0_addr  in  ADDR_BITS  read port 0 address.
- rd0_enable  in  1  read port 0 request.
- rd0_data  out  DATA_BITS  read port 0 data, registered.
- rd0_ready  out  1  rd0_data is valid and not stale, registered.
- rd1_addr / rd1_enable / rd1_data / rd1_ready: same as port 0.
- wr_addr  in  ADDR_BITS  writeback address.
- wr_enable  in  1  writeback strobe; also clears busy.
- wr_data  in  DATA_BITS  writeback data.
- rsv_addr  in  ADDR_BITS  destination to reserve.
- rsv_enable  in  1  reservation request.
- rsv_ok  out  1  combinational: reservation would be accepted this cycle.
- busy_mask  out  NUM_REGS  registered scoreboard, one bit per register.
- err_double_rsv  out  1  sticky: a reservation was refused.

Behaviour:
Reset:
- Sampled at a rising edge with reset==0.
- Clears all registers, busy_mask, rdN_data, rdN_ready and err_double_rsv.
- Reset overrides every concurrent write, read and reservation, including mid-operation.

Write:
- wr_enable=1 and wr_addr<NUM_REGS: reg[wr_addr] <= wr_data at the edge.
- Writes to wr_addr>=NUM_REGS are ignored.

Read (latency 1):
- At an edge with rdN_enable=1:
  - rdN_data <= reg[rdN_addr], or wr_data if wr_enable and wr_addr==rdN_addr in the same cycle (write-first bypass).
  - rdN_ready <= (busy[rdN_addr]==0) or a same-cycle write to rdN_addr.
- Out-of-range address: data 0, ready 1.
- rdN_enable=0: rdN_data holds its value and rdN_ready <= 0.
- Both ports may read the same address in the same cycle.

Scoreboard:
- rsv_ok = rsv_addr<NUM_REGS and (busy[rsv_addr]==0 or (wr_enable and wr_addr==rsv_addr)).
- rsv_enable and rsv_ok: busy[rsv_addr] <= 1.
- rsv_enable and not rsv_ok: no busy change; err_double_rsv <= 1 and stays set until reset.
- wr_enable: busy[wr_addr] <= 0, unless reserved in the same cycle.
- Same-cycle rsv and wr to the same address: data is written and busy ends at 1 (the new producer wins).
- A write to a non-busy register is legal and leaves busy at 0.

Arithmetic:
- No arithmetic on data.
- Address comparisons are zero-extended to ADDR_BITS.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Reads of address 0 return 0 with ready 1; bypass does not apply to address 0.
  - Writes to address 0 are dropped.
  - busy[0] is constant 0.
  - A reservation of address 0 is accepted (rsv_ok=1) as a no-op and never sets the error.
- Undefined: register 0 behaves like every other register.

Decomposition:
- constants_pkg:
  - add REGFILE_NUM_REGS = 16;
  - add typedef regfile_busy_t (logic [REGFILE_NUM_REGS-1:0]);
  - reuse the existing REGISTER_DATA_BITS.
- Sub-module regfile_read_port:
  - contains the address mux, bypass compare, output data/ready flops and the enable-hold logic;
  - instantiated twice.
- Storage, write decode and scoreboard stay in register_file_sb.

Test Plan:
- Reset: hold reset=0 for 2 cycles with wr_enable=1 -> rd0/rd1_data=0, busy_mask=0, err_double_rsv=0.
- Write then read: write reg5=0xA5 at T0; rd0_addr=5 at T1 -> rd0_data=0xA5, rd0_ready=1 at T2.
- Bypass: in one cycle wr reg3=0x3C with rd1_addr=3 -> next cycle rd1_data=0x3C, rd1_ready=1.
- Scoreboard:
  - rsv reg7 at T0 -> busy_mask[7]=1; read reg7 -> ready=0;
  - wr reg7=0x11 at T3 -> busy_mask[7]=0, a read at T4 returns 0x11 with ready=1.
- Double reservation / same-cycle rsv+wr:
  - rsv reg2 twice without a write -> rsv_ok=0 on the second request, err_double_rsv=1 (sticky);
  - rsv and wr reg9 together -> data written, busy_mask[9]=1.
- REGFILE_ZERO_REG_EN build: write reg0=0xFF, then read -> 0 with ready=1; rsv reg0 -> busy_mask[0]=0, no error.
